// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: program counter, next-PC selection, ROM address generation
// and the IF/ID pipeline register with a sticky out-of-range fetch flag.
module instruction_fetch_stage #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  input  logic                  jr,
  input  logic [DATA_WIDTH-1:0] jr_target,
  output logic [DATA_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_instruction,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] if_id_instruction,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic                  fetch_fault
);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_if_id_instruction;
  logic [DATA_WIDTH-1:0] r_if_id_pc_plus4;
  logic                  r_if_id_valid;
  logic                  r_fetch_fault;

  logic [DATA_WIDTH-1:0] w_imem_address;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_word_index;
  logic [DATA_WIDTH-1:0] w_jump_target;
  logic [DATA_WIDTH-1:0] w_next_pc;
  logic                  w_in_range;
  logic                  w_redirect;

  assign w_imem_address = r_pc - RESET_PC;
  assign w_pc_plus4     = r_pc + DATA_WIDTH'(4);
  assign w_word_index   = w_imem_address >> 2;
  assign w_in_range     = (w_imem_address[1:0] == 2'b00) &&
                          (w_word_index < DATA_WIDTH'(MEMORY_DEPTH));
  assign w_redirect     = jr | jump | branch_taken;
  // J-type target keeps the region bits of the delay-slot PC held in IF/ID.
  assign w_jump_target  = {r_if_id_pc_plus4[DATA_WIDTH-1 -: 4], jump_index, 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jr)                w_next_pc = jr_target;
    else if (jump)         w_next_pc = w_jump_target;
    else if (branch_taken) w_next_pc = branch_target;
    else if (stall)        w_next_pc = r_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc                <= RESET_PC;
      r_if_id_instruction <= '0;
      r_if_id_pc_plus4    <= '0;
      r_if_id_valid       <= 1'b0;
      r_fetch_fault       <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (flush || w_redirect) begin
        r_if_id_instruction <= '0;
        r_if_id_pc_plus4    <= '0;
        r_if_id_valid       <= 1'b0;
      end else if (!stall) begin
        r_if_id_pc_plus4 <= w_pc_plus4;
        if (w_in_range) begin
          r_if_id_instruction <= imem_instruction;
          r_if_id_valid       <= 1'b1;
        end else begin
          // Never hand garbage from outside the ROM to decode.
          r_if_id_instruction <= '0;
          r_if_id_valid       <= 1'b0;
          r_fetch_fault       <= 1'b1;
        end
      end
    end
  end

  assign imem_address      = w_imem_address;
  assign pc                = r_pc;
  assign if_id_instruction = r_if_id_instruction;
  assign if_id_pc_plus4    = r_if_id_pc_plus4;
  assign if_id_valid       = r_if_id_valid;
  assign fetch_fault       = r_fetch_fault;

endmodule
